// File: rtl/serial_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_addsub                                                |
// | Description : Bit-serial WL-bit adder/subtractor, LSB first, with carry    |
// |               and signed-overflow flags and a parallel result register.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module serial_addsub #(
  parameter int WL = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Load,
  input  logic          Sub,
  input  logic [WL-1:0] a,
  input  logic [WL-1:0] b,
  output logic          sbit,
  output logic          Busy,
  output logic          Done,
  output logic [WL-1:0] sum,
  output logic          Cout,
  output logic          Ovf
);

  localparam int          c_CW    = $clog2(WL + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WL - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [WL-1:0]   r_a;
  logic [WL-1:0]   r_b;
  logic            r_c;
  logic [c_CW-1:0] r_cnt;
  logic            w_s;
  logic            w_cn;
  logic            w_last;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (Load) w_next = c_SHIFT;
      c_SHIFT: if (w_last) w_next = c_DONE;
      c_DONE:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Busy = (r_state != c_IDLE);
    Done = (r_state == c_DONE);
  end

  assign w_last = (r_cnt == c_LAST);
  assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cn   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

  // Datapath; subtraction is a + ~b + 1 with the +1 seeded through the carry
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
      sbit  <= 1'b0;
      sum   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (Load) begin
            r_a   <= a;
            r_b   <= Sub ? ~b : b;
            r_c   <= Sub;
            r_cnt <= '0;
            sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
          end
        end
        c_SHIFT: begin
          sbit  <= w_s;
          sum   <= {w_s, sum[WL-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_cn;
          r_cnt <= r_cnt + c_CW'(1);
          // On the MSB, r_c is the carry into the MSB
          if (w_last) begin
            Cout <= w_cn;
            Ovf  <= r_c ^ w_cn;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_serial_addsub                                             |
// | Description : Directed self-checking bench for serial_addsub at WL=4.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_serial_addsub;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Load = 1'b0;
  logic       Sub = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       sbit;
  logic       Busy;
  logic       Done;
  logic [3:0] sum;
  logic       Cout;
  logic       Ovf;

  int checks = 0;
  int failures = 0;

  serial_addsub #(.WL(4)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .Load (Load),
    .Sub  (Sub),
    .a    (a),
    .b    (b),
    .sbit (sbit),
    .Busy (Busy),
    .Done (Done),
    .sum  (sum),
    .Cout (Cout),
    .Ovf  (Ovf)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One full operation; operand inputs are scrambled after the Load edge
  task automatic run_op(input string tag, input logic s, input logic [3:0] av,
                        input logic [3:0] bv, input logic [3:0] es,
                        input logic ec, input logic eo);
    Sub = s; a = av; b = bv; Load = 1'b1;
    step();
    Load = 1'b0; a = ~av; b = ~bv; Sub = ~s;
    check({tag, "_busy_start"}, 32'(Busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("%s_sbit%0d", tag, i), 32'(sbit), 32'(es[i]));
      check($sformatf("%s_done%0d", tag, i), 32'(Done), (i == 3) ? 32'd1 : 32'd0);
    end
    check({tag, "_sum"},  32'(sum),  32'(es));
    check({tag, "_cout"}, 32'(Cout), 32'(ec));
    check({tag, "_ovf"},  32'(Ovf),  32'(eo));
    step();
    check({tag, "_done_off"}, 32'(Done), 32'd0);
    check({tag, "_busy_off"}, 32'(Busy), 32'd0);
    check({tag, "_sum_hold"}, 32'(sum),  32'(es));
    check({tag, "_sbit_hold"}, 32'(sbit), 32'(es[3]));
    Sub = 1'b0; a = '0; b = '0;
  endtask

  initial begin
    int busy_cycles;
    int done_seen;

    // Reset, with a competing Load that must be discarded
    RST = 1'b1; Load = 1'b1; a = 4'b1111; b = 4'b1111;
    step();
    RST = 1'b0; Load = 1'b0; a = '0; b = '0;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_sbit", 32'(sbit), 32'd0);
    check("rst_cout", 32'(Cout), 32'd0);
    check("rst_ovf",  32'(Ovf),  32'd0);
    step();
    check("rst_load_dropped", 32'(Busy), 32'd0);

    run_op("add_ff",   1'b0, 4'b1111, 4'b1111, 4'b1110, 1'b1, 1'b0);
    run_op("add_ovf",  1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1);
    run_op("sub_pos",  1'b1, 4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0);
    run_op("sub_neg",  1'b1, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0);
    run_op("sub_ovf",  1'b1, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1);
    run_op("sub_eq",   1'b1, 4'b0110, 4'b0110, 4'b0000, 1'b1, 1'b0);

    // Load during SHIFT is ignored: 0101+0011 = 1000, Cout=0, Ovf=1
    Sub = 1'b0; a = 4'b0101; b = 4'b0011; Load = 1'b1;
    step();
    Load = 1'b0;
    busy_cycles = 0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (Busy) busy_cycles++;
      if (Done) done_seen++;
      if (i == 1) begin
        Load = 1'b1; Sub = 1'b1; a = 4'b1111; b = 4'b0001;
      end else begin
        Load = 1'b0;
      end
      step();
    end
    check("reload_busy_cycles", 32'(busy_cycles), 32'd5);
    check("reload_done_count",  32'(done_seen),   32'd1);
    check("reload_sum",  32'(sum),  32'b1000);
    check("reload_cout", 32'(Cout), 32'd0);
    check("reload_ovf",  32'(Ovf),  32'd1);

    // Reset in the 3rd SHIFT cycle aborts with no Done
    Sub = 1'b0; a = 4'b1111; b = 4'b1111; Load = 1'b1;
    step();
    Load = 1'b0;
    step();
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_sbit", 32'(sbit), 32'd0);
    check("abort_cout", 32'(Cout), 32'd0);
    check("abort_ovf",  32'(Ovf),  32'd0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (Done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_op("post_abort", 1'b0, 4'b0010, 4'b0011, 4'b0101, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
